// File: rtl/vend_pkg.sv
// Shared types and coin helpers for the vending transaction sequencer.
// Coin codes are the 2-bit encodings used on both the coin input and the change output.
package vend_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEND_WAIT,
        S_VEND,
        S_VEND_GAP,
        S_CHG_WAIT,
        S_CHG,
        S_CHG_GAP
    } state_t;

    localparam logic [1:0] CODE_5   = 2'd0;
    localparam logic [1:0] CODE_10  = 2'd1;
    localparam logic [1:0] CODE_25  = 2'd2;
    localparam logic [1:0] CODE_BAD = 2'd3;

    localparam logic [7:0] COIN_5  = 8'd5;
    localparam logic [7:0] COIN_10 = 8'd10;
    localparam logic [7:0] COIN_25 = 8'd25;

    function automatic logic [7:0] coin_value(input logic [1:0] code);
        case (code)
            CODE_5:  coin_value = COIN_5;
            CODE_10: coin_value = COIN_10;
            CODE_25: coin_value = COIN_25;
            default: coin_value = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_pulse_timer.sv
// Load/count-down phase timer for actuator pulse and gap timing.
// done is high while the count is zero; a load value of N gives N+1 cycles before done.
module vend_pulse_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: credit accumulation, item selection and sequencing
// of the shared dispense actuator (vend pulse, then greedy change-coin pulses).
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int          CREDIT_W  = 8,
    parameter logic [31:0] PRICES    = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int          PULSE_CYC = 4,
    parameter int          GAP_CYC   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                sel_valid,
    input  logic [1:0]          sel_item,
    input  logic                cancel,
    input  logic                act_ready,
    output logic                vend_pulse,
    output logic [1:0]          vend_item,
    output logic                chg_pulse,
    output logic [1:0]          chg_coin,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject,
    output logic                err_insuf
);

    localparam int CW1     = CREDIT_W + 1;
    localparam int TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYC - 1);

    state_t              state_reg, state_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic [1:0]          item_reg, item_next;
    logic [1:0]          chg_coin_reg, chg_coin_next;
    logic                coin_reject_reg, coin_reject_next;
    logic                err_insuf_reg, err_insuf_next;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_done;

    logic [7:0]          price_tbl [4];
    logic [CW1-1:0]      credit_ext, coin_sum, sel_price;
    logic [1:0]          greedy_code;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_price
            assign price_tbl[gi] = PRICES[8*gi +: 8];
        end
    endgenerate

    assign credit_ext = {1'b0, credit_reg};
    assign coin_sum   = credit_ext + CW1'(coin_value(coin_code));
    assign sel_price  = CW1'(price_tbl[sel_item]);

    // Greedy change: largest coin not exceeding the remaining credit.
    always_comb begin
        greedy_code = CODE_5;
        if (credit_ext >= CW1'(COIN_25)) begin
            greedy_code = CODE_25;
        end else if (credit_ext >= CW1'(COIN_10)) begin
            greedy_code = CODE_10;
        end
    end

    vend_pulse_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_next       = state_reg;
        credit_next      = credit_reg;
        item_next        = item_reg;
        chg_coin_next    = chg_coin_reg;
        coin_reject_next = 1'b0;
        err_insuf_next   = 1'b0;
        tmr_load         = 1'b0;
        tmr_val          = '0;

        if (coin_valid && state_reg != S_IDLE) begin
            coin_reject_next = 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                if (cancel) begin
                    coin_reject_next = coin_valid;
                    if (credit_reg != '0) begin
                        state_next = S_CHG_WAIT;
                    end
                end else if (sel_valid) begin
                    coin_reject_next = coin_valid;
                    if (credit_ext >= sel_price) begin
                        item_next  = sel_item;
                        state_next = S_VEND_WAIT;
                    end else begin
                        err_insuf_next = 1'b1;
                    end
                end else if (coin_valid) begin
                    // Top bit of the widened sum flags credit overflow.
                    if (coin_code == CODE_BAD || coin_sum[CREDIT_W]) begin
                        coin_reject_next = 1'b1;
                    end else begin
                        credit_next = coin_sum[CREDIT_W-1:0];
                    end
                end
            end
            S_VEND_WAIT: begin
                if (act_ready) begin
                    credit_next = credit_reg - CREDIT_W'(price_tbl[item_reg]);
                    state_next  = S_VEND;
                    tmr_load    = 1'b1;
                    tmr_val     = PULSE_LOAD;
                end
            end
            S_VEND: begin
                if (tmr_done) begin
                    state_next = S_VEND_GAP;
                    tmr_load   = 1'b1;
                    tmr_val    = GAP_LOAD;
                end
            end
            S_VEND_GAP, S_CHG_GAP: begin
                if (tmr_done) begin
                    state_next = (credit_reg != '0) ? S_CHG_WAIT : S_IDLE;
                end
            end
            S_CHG_WAIT: begin
                if (act_ready) begin
                    credit_next   = credit_reg - CREDIT_W'(coin_value(greedy_code));
                    chg_coin_next = greedy_code;
                    state_next    = S_CHG;
                    tmr_load      = 1'b1;
                    tmr_val       = PULSE_LOAD;
                end
            end
            S_CHG: begin
                if (tmr_done) begin
                    state_next = S_CHG_GAP;
                    tmr_load   = 1'b1;
                    tmr_val    = GAP_LOAD;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            credit_reg      <= '0;
            item_reg        <= 2'd0;
            chg_coin_reg    <= 2'd0;
            coin_reject_reg <= 1'b0;
            err_insuf_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            credit_reg      <= credit_next;
            item_reg        <= item_next;
            chg_coin_reg    <= chg_coin_next;
            coin_reject_reg <= coin_reject_next;
            err_insuf_reg   <= err_insuf_next;
        end
    end

    assign vend_pulse  = (state_reg == S_VEND);
    assign vend_item   = item_reg;
    assign chg_pulse   = (state_reg == S_CHG);
    assign chg_coin    = chg_coin_reg;
    assign credit      = credit_reg;
    assign busy        = (state_reg != S_IDLE);
    assign coin_reject = coin_reject_reg;
    assign err_insuf   = err_insuf_reg;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: scenario tasks with inline checks and a pulse monitor.
// Item prices follow PRICES[8*i+:8]: item0=10, item1=15, item2=20, item3=25.
`timescale 1ns/1ps
module tb_vend_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_code = 2'd0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_item = 2'd0;
    logic       cancel = 1'b0;
    logic       act_ready = 1'b1;
    logic       vend_pulse, chg_pulse, busy, coin_reject, err_insuf;
    logic [1:0] vend_item, chg_coin;
    logic [7:0] credit;

    int chk_cnt = 0;
    int pass_cnt = 0;

    vend_sequencer dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_code(coin_code),
        .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel), .act_ready(act_ready),
        .vend_pulse(vend_pulse), .vend_item(vend_item), .chg_pulse(chg_pulse),
        .chg_coin(chg_coin), .credit(credit), .busy(busy),
        .coin_reject(coin_reject), .err_insuf(err_insuf)
    );

    always #5 clk = ~clk;

    // Pulse monitor: records every completed pulse and the shortest low run between pulses.
    typedef struct { bit is_chg; logic [1:0] val; int width; } rec_t;
    rec_t pq[$];
    bit         mon_in = 0, mon_seen = 0, mon_kind = 0;
    logic [1:0] mon_val = 2'd0;
    int         mon_w = 0, mon_low = 0, min_low = 1000, overlap_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            mon_in = 0; mon_seen = 0; mon_low = 0;
        end else begin
            if (vend_pulse && chg_pulse) overlap_cnt++;
            if (vend_pulse || chg_pulse) begin
                if (!mon_in) begin
                    if (mon_seen && mon_low < min_low) min_low = mon_low;
                    mon_in = 1; mon_w = 0;
                    mon_kind = chg_pulse;
                    mon_val = chg_pulse ? chg_coin : vend_item;
                end
                mon_w++;
            end else begin
                if (mon_in) begin
                    pq.push_back('{is_chg: mon_kind, val: mon_val, width: mon_w});
                    mon_in = 0; mon_seen = 1; mon_low = 0;
                end
                mon_low++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] code);
        coin_valid = 1'b1; coin_code = code;
        tick();
        coin_valid = 1'b0;
        $display("[tb] coin code=%0d -> credit=%0d reject=%0b", code, credit, coin_reject);
    endtask

    task automatic select(input logic [1:0] item);
        sel_valid = 1'b1; sel_item = item;
        tick();
        sel_valid = 1'b0;
        sel_item = ~item;
        $display("[tb] select item=%0d -> busy=%0b err_insuf=%0b credit=%0d", item, busy, err_insuf, credit);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy) begin ok = 1; break; end
        end
        $display("[tb] wait_idle ok=%0b credit=%0d pulses=%0d", ok, credit, pq.size());
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        chk_cnt++; if (credit !== 8'd0) $display("FAIL reset_credit: got %0d want 0", credit); else pass_cnt++;
        chk_cnt++; if ({busy, vend_pulse, chg_pulse, coin_reject, err_insuf} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {busy, vend_pulse, chg_pulse, coin_reject, err_insuf});
        else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_exact_vend();
        bit ok;
        pq.delete();
        put_coin(2'd1);
        put_coin(2'd1);
        chk_cnt++; if (credit !== 8'd20) $display("FAIL exact_credit: got %0d want 20", credit); else pass_cnt++;
        select(2'd2);
        chk_cnt++; if (busy !== 1'b1 || vend_pulse !== 1'b0 || credit !== 8'd20)
            $display("FAIL exact_wait: busy=%b pulse=%b credit=%0d want 1 0 20", busy, vend_pulse, credit);
        else pass_cnt++;
        tick();
        chk_cnt++; if (vend_pulse !== 1'b1 || credit !== 8'd0)
            $display("FAIL exact_latency: pulse=%b credit=%0d want 1 0", vend_pulse, credit);
        else pass_cnt++;
        wait_idle(100, ok);
        chk_cnt++; if (!ok) $display("FAIL exact_idle: busy=%b want 0", busy); else pass_cnt++;
        chk_cnt++; if (pq.size() != 1 || pq[0].is_chg || pq[0].val !== 2'd2 || pq[0].width != 4)
            $display("FAIL exact_pulse: count=%0d want 1 vend pulse item 2 width 4", pq.size());
        else pass_cnt++;
        chk_cnt++; if (credit !== 8'd0) $display("FAIL exact_final_credit: got %0d want 0", credit); else pass_cnt++;
    endtask

    task automatic test_change();
        bit ok;
        bit         exp_c [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0] exp_v [4] = '{2'd0, 2'd2, 2'd1, 2'd0};
        pq.delete(); min_low = 1000; overlap_cnt = 0;
        put_coin(2'd2);
        put_coin(2'd2);
        chk_cnt++; if (credit !== 8'd50) $display("FAIL change_credit: got %0d want 50", credit); else pass_cnt++;
        select(2'd0);
        wait_idle(200, ok);
        chk_cnt++; if (!ok || pq.size() != 4) $display("FAIL change_count: ok=%b pulses=%0d want 4", ok, pq.size());
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if (i >= pq.size()) $display("FAIL change_pulse%0d: missing, want kind=%0d val=%0d", i, exp_c[i], exp_v[i]);
            else if (pq[i].is_chg !== exp_c[i] || pq[i].val !== exp_v[i] || pq[i].width != 4)
                $display("FAIL change_pulse%0d: kind=%0d val=%0d width=%0d want %0d %0d 4",
                         i, pq[i].is_chg, pq[i].val, pq[i].width, exp_c[i], exp_v[i]);
            else pass_cnt++;
        end
        chk_cnt++; if (min_low < 2) $display("FAIL change_gap: min low=%0d want >=2", min_low); else pass_cnt++;
        chk_cnt++; if (overlap_cnt != 0) $display("FAIL change_overlap: got %0d want 0", overlap_cnt); else pass_cnt++;
        chk_cnt++; if (credit !== 8'd0) $display("FAIL change_final_credit: got %0d want 0", credit); else pass_cnt++;
    endtask

    task automatic test_insufficient();
        bit ok;
        pq.delete();
        put_coin(2'd0);
        select(2'd1);
        chk_cnt++; if (err_insuf !== 1'b1 || credit !== 8'd5 || busy !== 1'b0)
            $display("FAIL insuf_flag: err=%b credit=%0d busy=%b want 1 5 0", err_insuf, credit, busy);
        else pass_cnt++;
        tick();
        chk_cnt++; if (err_insuf !== 1'b0) $display("FAIL insuf_oneshot: got %b want 0", err_insuf); else pass_cnt++;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        $display("[tb] cancel -> busy=%0b credit=%0d", busy, credit);
        chk_cnt++; if (busy !== 1'b1) $display("FAIL cancel_busy: got %b want 1", busy); else pass_cnt++;
        wait_idle(100, ok);
        chk_cnt++; if (!ok || pq.size() != 1 || !pq[0].is_chg || pq[0].val !== 2'd0 || pq[0].width != 4)
            $display("FAIL cancel_refund: ok=%b pulses=%0d want one 5-coin change pulse", ok, pq.size());
        else pass_cnt++;
        chk_cnt++; if (credit !== 8'd0) $display("FAIL cancel_credit: got %0d want 0", credit); else pass_cnt++;
    endtask

    task automatic test_reject();
        bit ok;
        pq.delete();
        for (int i = 0; i < 10; i++) put_coin(2'd2);
        chk_cnt++; if (credit !== 8'd250) $display("FAIL reject_fill: got %0d want 250", credit); else pass_cnt++;
        put_coin(2'd1);
        chk_cnt++; if (coin_reject !== 1'b1 || credit !== 8'd250)
            $display("FAIL reject_overflow: rej=%b credit=%0d want 1 250", coin_reject, credit);
        else pass_cnt++;
        put_coin(2'd3);
        chk_cnt++; if (coin_reject !== 1'b1 || credit !== 8'd250)
            $display("FAIL reject_invalid: rej=%b credit=%0d want 1 250", coin_reject, credit);
        else pass_cnt++;
        tick();
        chk_cnt++; if (coin_reject !== 1'b0) $display("FAIL reject_oneshot: got %b want 0", coin_reject); else pass_cnt++;
        coin_valid = 1'b1; coin_code = 2'd0; sel_valid = 1'b1; sel_item = 2'd0;
        tick();
        coin_valid = 1'b0; sel_valid = 1'b0;
        $display("[tb] coin+select -> busy=%0b reject=%0b credit=%0d", busy, coin_reject, credit);
        chk_cnt++; if (busy !== 1'b1 || coin_reject !== 1'b1 || credit !== 8'd250)
            $display("FAIL reject_priority: busy=%b rej=%b credit=%0d want 1 1 250", busy, coin_reject, credit);
        else pass_cnt++;
        wait_idle(400, ok);
        chk_cnt++; if (!ok || pq.size() != 12 || pq[1].val !== 2'd2 || pq[10].val !== 2'd1 || pq[11].val !== 2'd0)
            $display("FAIL reject_change: ok=%b pulses=%0d want 12 (vend, 9x25, 10, 5)", ok, pq.size());
        else pass_cnt++;
        chk_cnt++; if (credit !== 8'd0) $display("FAIL reject_final_credit: got %0d want 0", credit); else pass_cnt++;
    endtask

    task automatic test_stall();
        bit ok;
        pq.delete();
        act_ready = 1'b0;
        put_coin(2'd1);
        select(2'd0);
        repeat (8) tick();
        chk_cnt++; if (busy !== 1'b1 || vend_pulse !== 1'b0 || credit !== 8'd10)
            $display("FAIL stall_hold: busy=%b pulse=%b credit=%0d want 1 0 10", busy, vend_pulse, credit);
        else pass_cnt++;
        put_coin(2'd0);
        chk_cnt++; if (coin_reject !== 1'b1 || credit !== 8'd10)
            $display("FAIL stall_coin: rej=%b credit=%0d want 1 10", coin_reject, credit);
        else pass_cnt++;
        act_ready = 1'b1;
        tick();
        chk_cnt++; if (vend_pulse !== 1'b1 || vend_item !== 2'd0 || credit !== 8'd0)
            $display("FAIL stall_release: pulse=%b item=%0d credit=%0d want 1 0 0", vend_pulse, vend_item, credit);
        else pass_cnt++;
        wait_idle(100, ok);
        chk_cnt++; if (!ok || pq.size() != 1) $display("FAIL stall_done: ok=%b pulses=%0d want 1", ok, pq.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_change();
        bit ok;
        bit prev = 0;
        int n = 0;
        put_coin(2'd2);
        put_coin(2'd2);
        select(2'd0);
        for (int i = 0; i < 200 && n < 2; i++) begin
            tick();
            if (chg_pulse && !prev) n++;
            prev = chg_pulse;
        end
        chk_cnt++; if (n != 2) $display("FAIL midrst_find: saw %0d change pulses want 2", n); else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("[tb] reset during change pulse -> chg_pulse=%0b credit=%0d busy=%0b", chg_pulse, credit, busy);
        chk_cnt++; if (chg_pulse !== 1'b0 || credit !== 8'd0 || busy !== 1'b0)
            $display("FAIL midrst_state: pulse=%b credit=%0d busy=%b want 0 0 0", chg_pulse, credit, busy);
        else pass_cnt++;
        tick();
        chk_cnt++; if (busy !== 1'b0 || chg_pulse !== 1'b0)
            $display("FAIL midrst_no_owed: busy=%b pulse=%b want 0 0", busy, chg_pulse);
        else pass_cnt++;
        put_coin(2'd2);
        chk_cnt++; if (credit !== 8'd25 || coin_reject !== 1'b0)
            $display("FAIL midrst_coin: credit=%0d rej=%b want 25 0", credit, coin_reject);
        else pass_cnt++;
        pq.delete();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        wait_idle(100, ok);
        chk_cnt++; if (!ok || pq.size() != 1 || pq[0].val !== 2'd2 || credit !== 8'd0)
            $display("FAIL midrst_refund: ok=%b pulses=%0d credit=%0d want 1 pulse of 25, credit 0", ok, pq.size(), credit);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_exact_vend();
        test_change();
        test_insufficient();
        test_reject();
        test_stall();
        test_reset_mid_change();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
